// File: rtl/trigger_staged_if.sv
// trigger_staged_if: configuration, sample and status bundle of the staged trigger.
//   cfg_wr/cfg_stage/cfg_reg/cfg_data : stage register write port
//   arm                               : restart the sequence at level 0
//   valid/dataIn                      : qualified sample stream from the sampler
//   run/armed/level                   : trigger status back to the controller
//   master modport drives config/samples, slave modport is the trigger unit.
interface trigger_staged_if #(
  parameter int unsigned SAMPLE_WIDTH = 8
);
  logic                    cfg_wr;
  logic [3:0]              cfg_stage;
  logic [1:0]              cfg_reg;
  logic [31:0]             cfg_data;
  logic                    arm;
  logic                    valid;
  logic [SAMPLE_WIDTH-1:0] dataIn;
  logic                    run;
  logic                    armed;
  logic [3:0]              level;

  modport master (
    output cfg_wr, cfg_stage, cfg_reg, cfg_data, arm, valid, dataIn,
    input  run, armed, level
  );

  modport slave (
    input  cfg_wr, cfg_stage, cfg_reg, cfg_data, arm, valid, dataIn,
    output run, armed, level
  );
endinterface

// File: rtl/trigger_staged.sv
// trigger_staged: multi-stage sequential mask/value trigger for the sampler path.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset (clears configuration too)
//   bus     : trigger_staged_if.slave (config writes, arm, samples, run/armed/level)
// Each stage matches ((dataIn ^ value) & mask) == 0, optionally as a rising
// edge of that match, then waits D valid samples before completing. The last
// stage, or any stage flagged final, fires the sticky run output.
// Optional: define TRIGGER_OCCURRENCE_EN to require N+1 qualifying matches per
// stage (N from config bits [31:24]); without it the stage completes on its
// first match and no occurrence logic exists.
module trigger_staged #(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned DELAY_WIDTH  = 16
) (
  input logic             clock,
  input logic             reset_n,
  trigger_staged_if.slave bus
);

  localparam int unsigned LEVEL_WIDTH = 4;
  localparam logic [LEVEL_WIDTH-1:0] LAST_LEVEL = LEVEL_WIDTH'(NUM_STAGES - 1);
`ifdef TRIGGER_OCCURRENCE_EN
  localparam int unsigned OCC_WIDTH = 8;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, DELAY, FIRED} state_t;

  typedef struct packed {
`ifdef TRIGGER_OCCURRENCE_EN
    logic [OCC_WIDTH-1:0]   occ;
`endif
    logic                   final_en;
    logic                   edge_en;
    logic [DELAY_WIDTH-1:0] delay;
  } stage_cfg_t;

  state_t                  state_q, state_d;
  logic [LEVEL_WIDTH-1:0]  level_q, level_d;
  logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    run_q, run_d;
  logic                    armed_q, armed_d;
  logic [NUM_STAGES-1:0]   prev_match_q, prev_match_d;
  logic                    prev_seen_q, prev_seen_d;
`ifdef TRIGGER_OCCURRENCE_EN
  logic [OCC_WIDTH-1:0]    occ_cnt_q, occ_cnt_d;
`endif

  logic [SAMPLE_WIDTH-1:0] mask_q  [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] value_q [NUM_STAGES];
  stage_cfg_t              cfg_q   [NUM_STAGES];

  logic                    cfg_en_c;
  stage_cfg_t              cfg_word_c;
  logic [NUM_STAGES-1:0]   raw_match_c;
  stage_cfg_t              cur_cfg_c;
  logic                    cur_raw_c;
  logic                    cur_prev_c;
  logic                    qual_c;
  logic                    occ_pending_c;
  logic                    stage_done_c;
  logic                    unused_cfg;

  // Only the low SAMPLE_WIDTH/DELAY_WIDTH bits and a few flags are meaningful.
  assign unused_cfg = ^bus.cfg_data;

  // Configuration is frozen while a sequence is in progress.
  assign cfg_en_c = bus.cfg_wr && (state_q == IDLE || state_q == FIRED) &&
                    (32'(bus.cfg_stage) < NUM_STAGES);

  // Unpack the config word into its stage fields.
  always_comb begin
    cfg_word_c          = '0;
    cfg_word_c.delay    = bus.cfg_data[DELAY_WIDTH-1:0];
    cfg_word_c.edge_en  = bus.cfg_data[16];
    cfg_word_c.final_en = bus.cfg_data[17];
`ifdef TRIGGER_OCCURRENCE_EN
    cfg_word_c.occ      = bus.cfg_data[31:24];
`endif
  end

  // Stage register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        mask_q[i]  <= '0;
        value_q[i] <= '0;
        cfg_q[i]   <= '0;
      end
    end else if (cfg_en_c) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        if (bus.cfg_stage == LEVEL_WIDTH'(i)) begin
          case (bus.cfg_reg)
            2'd0:    mask_q[i]  <= bus.cfg_data[SAMPLE_WIDTH-1:0];
            2'd1:    value_q[i] <= bus.cfg_data[SAMPLE_WIDTH-1:0];
            2'd2:    cfg_q[i]   <= cfg_word_c;
            default: ;
          endcase
        end
      end
    end
  end

  // Raw match of every stage; all stages feed the previous-match flags.
  always_comb begin
    raw_match_c = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      raw_match_c[i] = ((bus.dataIn ^ value_q[i]) & mask_q[i]) == '0;
    end
  end

  // Select the fields of the stage at the current level.
  always_comb begin
    cur_cfg_c  = '0;
    cur_raw_c  = 1'b0;
    cur_prev_c = 1'b0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (level_q == LEVEL_WIDTH'(i)) begin
        cur_cfg_c  = cfg_q[i];
        cur_raw_c  = raw_match_c[i];
        cur_prev_c = prev_match_q[i];
      end
    end
  end

  // Edge mode needs a prior sample since arm that did not match.
  assign qual_c = cur_raw_c && (!cur_cfg_c.edge_en || (!cur_prev_c && prev_seen_q));

`ifdef TRIGGER_OCCURRENCE_EN
  assign occ_pending_c = occ_cnt_q != cur_cfg_c.occ;
`else
  assign occ_pending_c = 1'b0;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    run_d        = run_q;
    prev_match_d = prev_match_q;
    prev_seen_d  = prev_seen_q;
    stage_done_c = 1'b0;
`ifdef TRIGGER_OCCURRENCE_EN
    occ_cnt_d    = occ_cnt_q;
`endif

    if (bus.arm) begin
      state_d      = ARMED;
      level_d      = '0;
      cnt_d        = '0;
      run_d        = 1'b0;
      prev_match_d = '0;
      prev_seen_d  = 1'b0;
`ifdef TRIGGER_OCCURRENCE_EN
      occ_cnt_d    = '0;
`endif
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.valid) begin
            prev_match_d = raw_match_c;
            prev_seen_d  = 1'b1;
            if (qual_c) begin
              if (occ_pending_c) begin
`ifdef TRIGGER_OCCURRENCE_EN
                occ_cnt_d = occ_cnt_q + 1'b1;
`endif
              end else if (cur_cfg_c.delay == '0) begin
                stage_done_c = 1'b1;
              end else begin
                cnt_d   = cur_cfg_c.delay;
                state_d = DELAY;
              end
            end
          end
        end
        DELAY: begin
          if (bus.valid) begin
            prev_match_d = raw_match_c;
            prev_seen_d  = 1'b1;
            if (cnt_q <= DELAY_WIDTH'(1)) begin
              cnt_d        = '0;
              stage_done_c = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: ;
      endcase

      // A completed stage either fires or advances; the last level never wraps.
      if (stage_done_c) begin
        if (cur_cfg_c.final_en || level_q == LAST_LEVEL) begin
          state_d = FIRED;
          run_d   = 1'b1;
        end else begin
          state_d = ARMED;
          level_d = level_q + 1'b1;
`ifdef TRIGGER_OCCURRENCE_EN
          occ_cnt_d = '0;
`endif
        end
      end
    end

    armed_d = (state_d == ARMED) || (state_d == DELAY);
  end

  // Sequencer state and registered status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      level_q      <= '0;
      cnt_q        <= '0;
      run_q        <= 1'b0;
      armed_q      <= 1'b0;
      prev_match_q <= '0;
      prev_seen_q  <= 1'b0;
`ifdef TRIGGER_OCCURRENCE_EN
      occ_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      run_q        <= run_d;
      armed_q      <= armed_d;
      prev_match_q <= prev_match_d;
      prev_seen_q  <= prev_seen_d;
`ifdef TRIGGER_OCCURRENCE_EN
      occ_cnt_q    <= occ_cnt_d;
`endif
    end
  end

  assign bus.run   = run_q;
  assign bus.armed = armed_q;
  assign bus.level = level_q;

endmodule

// File: tb/tb_trigger_staged.sv
// tb_trigger_staged: directed and randomized checks of trigger_staged against
// a sample-by-sample behavioural model of the trigger sequence.
module tb_trigger_staged;

  localparam int NS = 4;
  localparam int P_IDLE = 0, P_HUNT = 1, P_WAIT = 2, P_FIRED = 3;
  localparam logic [31:0] FINAL = 32'h0002_0000;
  localparam logic [31:0] EDGE  = 32'h0001_0000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  trigger_staged_if #(.SAMPLE_WIDTH(8)) bus ();

  trigger_staged #(.SAMPLE_WIDTH(8), .NUM_STAGES(NS), .DELAY_WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: stage programs plus where the sequence currently is.
  int m_mask[NS], m_value[NS], m_delay[NS], m_occ[NS];
  bit m_edge[NS], m_final[NS], m_prev[NS];
  bit m_seen, m_run;
  int m_phase, m_level, m_wait, m_hits;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_mask[i] = 0; m_value[i] = 0; m_delay[i] = 0; m_occ[i] = 0;
      m_edge[i] = 0; m_final[i] = 0; m_prev[i] = 0;
    end
    m_seen = 0; m_run = 0; m_phase = P_IDLE; m_level = 0; m_wait = 0; m_hits = 0;
  endtask

  task automatic model_step(input bit wr, input int stg, input int rg, input logic [31:0] data,
                            input bit a, input bit v, input int din);
    bit hit[NS];
    bit done;
    if (wr && (m_phase == P_IDLE || m_phase == P_FIRED) && stg < NS) begin
      case (rg)
        0: m_mask[stg]  = int'(data[7:0]);
        1: m_value[stg] = int'(data[7:0]);
        2: begin
          m_delay[stg] = int'(data[15:0]);
          m_edge[stg]  = data[16];
          m_final[stg] = data[17];
`ifdef TRIGGER_OCCURRENCE_EN
          m_occ[stg]   = int'(data[31:24]);
`else
          m_occ[stg]   = 0;
`endif
        end
        default: ;
      endcase
    end
    if (a) begin
      m_phase = P_HUNT; m_level = 0; m_wait = 0; m_hits = 0; m_run = 0; m_seen = 0;
      for (int i = 0; i < NS; i++) m_prev[i] = 0;
      return;
    end
    if (!v || !(m_phase == P_HUNT || m_phase == P_WAIT)) return;
    for (int i = 0; i < NS; i++) hit[i] = ((din ^ m_value[i]) & m_mask[i]) == 0;
    done = 0;
    if (m_phase == P_HUNT) begin
      if (hit[m_level] && (!m_edge[m_level] || (!m_prev[m_level] && m_seen))) begin
        if (m_hits < m_occ[m_level]) m_hits++;
        else if (m_delay[m_level] == 0) done = 1;
        else begin m_wait = m_delay[m_level]; m_phase = P_WAIT; end
      end
    end else begin
      m_wait--;
      if (m_wait == 0) done = 1;
    end
    for (int i = 0; i < NS; i++) m_prev[i] = hit[i];
    m_seen = 1;
    if (done) begin
      if (m_final[m_level] || m_level == NS - 1) begin
        m_phase = P_FIRED; m_run = 1;
      end else begin
        m_level++; m_hits = 0; m_phase = P_HUNT;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit wr, input int stg, input int rg, input logic [31:0] data,
                      input bit a, input bit v, input logic [7:0] din);
    bus.cfg_wr = wr; bus.cfg_stage = 4'(stg); bus.cfg_reg = 2'(rg); bus.cfg_data = data;
    bus.arm = a; bus.valid = v; bus.dataIn = din;
    model_step(wr, stg, rg, data, a, v, int'(din));
    @(posedge clock);
    #1;
    bus.cfg_wr = 1'b0; bus.arm = 1'b0; bus.valid = 1'b0;
  endtask

  task automatic cfg_write(input int stg, input int rg, input logic [31:0] data);
    step(1'b1, stg, rg, data, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic feed(input logic [7:0] d);
    step(1'b0, 0, 0, 32'h0, 1'b0, 1'b1, d);
  endtask

  task automatic gap();
    step(1'b0, 0, 0, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_arm();
    step(1'b0, 0, 0, 32'h0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.cfg_wr = 1'b0; bus.arm = 1'b0; bus.valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    do_reset();
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b0) begin miscompares++; $display("FAIL reset_state: got %b expected 000000", got); end
    // Program a restrictive stage 0, arm, then reset asynchronously mid-sequence.
    cfg_write(0, 0, 32'hFF); cfg_write(0, 1, 32'hA5);
    do_arm();
    #2 reset_n = 1'b0;
    #1 got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b0) begin miscompares++; $display("FAIL async_reset: got %b expected 000000", got); end
    model_reset();
    @(posedge clock); #1 reset_n = 1'b1;
    // Cleared config: mask 0 matches everything, last stage is implicitly final.
    do_arm();
    for (int k = 1; k <= NS; k++) begin
      feed(8'h00);
      got = {bus.run, bus.armed, bus.level};
      vectors++;
      if (k < NS && got !== {1'b0, 1'b1, 4'(k)}) begin
        miscompares++; $display("FAIL cleared_cfg_advance: got %b expected level %0d armed", got, k);
      end else if (k == NS && got !== {1'b1, 1'b0, 4'(NS - 1)}) begin
        miscompares++; $display("FAIL implicit_final: got %b expected run at level %0d", got, NS - 1);
      end
    end
  endtask

  task automatic test_single_stage();
    logic [5:0] got;
    do_reset();
    cfg_write(0, 0, 32'hFF); cfg_write(0, 1, 32'hA5); cfg_write(0, 2, FINAL);
    do_arm();
    feed(8'h00);
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b01_0000) begin miscompares++; $display("FAIL single_nomatch: got %b expected 010000", got); end
    feed(8'hA5);
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b10_0000) begin miscompares++; $display("FAIL single_fire: got %b expected 100000", got); end
    gap();
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b10_0000) begin miscompares++; $display("FAIL run_sticky: got %b expected 100000", got); end
  endtask

  task automatic test_two_stage();
    logic [5:0] got;
    logic [5:0] exp [3];
    logic [7:0] seq [3];
    do_reset();
    cfg_write(0, 0, 32'h0F); cfg_write(0, 1, 32'h03);
    cfg_write(1, 0, 32'hFF); cfg_write(1, 1, 32'h80); cfg_write(1, 2, FINAL);
    do_arm();
    seq[0] = 8'h80; exp[0] = 6'b01_0000;
    seq[1] = 8'h13; exp[1] = 6'b01_0001;
    seq[2] = 8'h80; exp[2] = 6'b10_0001;
    for (int k = 0; k < 3; k++) begin
      feed(seq[k]);
      got = {bus.run, bus.armed, bus.level};
      vectors++;
      if (got !== exp[k]) begin
        miscompares++; $display("FAIL two_stage[%0d]: got %b expected %b", k, got, exp[k]);
      end
    end
  endtask

  task automatic test_delay();
    logic [5:0] got;
    do_reset();
    cfg_write(0, 0, 32'hFF); cfg_write(0, 1, 32'hA5); cfg_write(0, 2, FINAL | 32'd3);
    do_arm();
    feed(8'hA5);
    for (int k = 1; k <= 3; k++) begin
      gap(); gap();
      got = {bus.run, bus.armed, bus.level};
      vectors++;
      if (got !== 6'b01_0000) begin miscompares++; $display("FAIL delay_gap[%0d]: got %b expected 010000", k, got); end
      feed(8'h00);
      got = {bus.run, bus.armed, bus.level};
      vectors++;
      if (got !== ((k == 3) ? 6'b10_0000 : 6'b01_0000)) begin
        miscompares++; $display("FAIL delay_count[%0d]: got %b expected run=%0d", k, got, k == 3);
      end
    end
  endtask

  task automatic test_edge();
    logic [5:0] got;
    logic [7:0] seq [4];
    bit         fire [4];
    do_reset();
    cfg_write(0, 0, 32'h01); cfg_write(0, 1, 32'h01); cfg_write(0, 2, FINAL | EDGE);
    do_arm();
    seq[0] = 8'h01; fire[0] = 0;  // no sample seen yet
    seq[1] = 8'h01; fire[1] = 0;  // matched previously
    seq[2] = 8'h00; fire[2] = 0;
    seq[3] = 8'h01; fire[3] = 1;
    for (int k = 0; k < 4; k++) begin
      feed(seq[k]);
      got = {bus.run, bus.armed, bus.level};
      vectors++;
      if (got !== (fire[k] ? 6'b10_0000 : 6'b01_0000)) begin
        miscompares++; $display("FAIL edge[%0d]: got %b expected run=%0d", k, got, fire[k]);
      end
    end
  endtask

  task automatic test_arm_priority();
    logic [5:0] got;
    do_reset();
    cfg_write(0, 0, 32'hFF); cfg_write(0, 1, 32'hA5); cfg_write(0, 2, FINAL);
    do_arm();
    step(1'b0, 0, 0, 32'h0, 1'b1, 1'b1, 8'hA5);
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b01_0000) begin miscompares++; $display("FAIL arm_priority: got %b expected 010000", got); end
    cfg_write(0, 1, 32'h5A);  // ignored while armed
    feed(8'h5A);
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b01_0000) begin miscompares++; $display("FAIL cfg_ignored_armed: got %b expected 010000", got); end
    feed(8'hA5);
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b10_0000) begin miscompares++; $display("FAIL old_value_fire: got %b expected 100000", got); end
    // Write concurrent with arm from FIRED lands and is used immediately after.
    step(1'b1, 0, 1, 32'h5A, 1'b1, 1'b0, 8'h00);
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b01_0000) begin miscompares++; $display("FAIL rearm_from_fired: got %b expected 010000", got); end
    feed(8'h5A);
    got = {bus.run, bus.armed, bus.level};
    vectors++;
    if (got !== 6'b10_0000) begin miscompares++; $display("FAIL cfg_with_arm: got %b expected 100000", got); end
  endtask

  task automatic test_occurrence();
    logic [5:0] got;
    logic [7:0] seq [4];
    bit         fire [4];
    do_reset();
    cfg_write(0, 0, 32'hFF); cfg_write(0, 1, 32'hA5); cfg_write(0, 2, FINAL | 32'h0200_0000);
    do_arm();
    seq[0] = 8'hA5; seq[1] = 8'h00; seq[2] = 8'hA5; seq[3] = 8'hA5;
`ifdef TRIGGER_OCCURRENCE_EN
    fire[0] = 0; fire[1] = 0; fire[2] = 0; fire[3] = 1;
`else
    fire[0] = 1; fire[1] = 1; fire[2] = 1; fire[3] = 1;
`endif
    for (int k = 0; k < 4; k++) begin
      feed(seq[k]);
      got = {bus.run, bus.armed, bus.level};
      vectors++;
      if (got !== (fire[k] ? 6'b10_0000 : 6'b01_0000)) begin
        miscompares++; $display("FAIL occurrence[%0d]: got %b expected run=%0d", k, got, fire[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  got, exp;
    logic [31:0] d;
    for (int r = 0; r < 20; r++) begin
      do_reset();
      for (int s = 0; s < NS; s++) begin
        cfg_write(s, 0, 32'($urandom_range(0, 3)));
        cfg_write(s, 1, 32'($urandom_range(0, 255)));
        d = 32'($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) d = d | EDGE;
        if ($urandom_range(0, 3) == 0) d = d | FINAL;
        if ($urandom_range(0, 1) == 1) d = d | 32'h0100_0000;
        cfg_write(s, 2, d);
      end
      cfg_write(NS, 0, 32'($urandom));              // out of range stage
      cfg_write($urandom_range(0, NS - 1), 3, 32'($urandom));  // reserved register
      do_arm();
      for (int c = 0; c < 80; c++) begin
        step($urandom_range(0, 11) == 0, $urandom_range(0, NS), $urandom_range(0, 3), 32'($urandom),
             $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
        got = {bus.run, bus.armed, bus.level};
        exp = {m_run, (m_phase == P_HUNT || m_phase == P_WAIT), 4'(m_level)};
        vectors++;
        if (got !== exp) begin
          miscompares++; $display("FAIL random r%0d c%0d: got %b expected %b", r, c, got, exp);
        end
      end
    end
  endtask

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_stage = '0; bus.cfg_reg = '0; bus.cfg_data = '0;
    bus.arm = 1'b0; bus.valid = 1'b0; bus.dataIn = '0;
    model_reset();
    test_reset();
    test_single_stage();
    test_two_stage();
    test_delay();
    test_edge();
    test_arm_priority();
    test_occurrence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
